// File: rtl/count_ena_ctrl.sv
// Run/stop/single-step controller producing the count-enable and clear pulses for a downstream counter.
// Optional input debounce filter is built when COUNT_ENA_DEBOUNCE_EN is defined.
module count_ena_ctrl #(
    parameter int PRESCALE_W = 24,
    parameter int DEB_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_run,
    input  logic                  btn_step,
    input  logic                  btn_clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  ena,
    output logic                  clr,
    output logic                  running
);

    // state | meaning
    // IDLE  | stopped, prescaler held at 0
    // RUN   | free running, ena every prescale+1 cycles
    // STEP  | single count, ena high for this one cycle
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;

    if (PRESCALE_W < 1 || DEB_W < 1) begin : g_param_check
        $error("count_ena_ctrl: PRESCALE_W and DEB_W must be >= 1");
    end

    // Button vectors are ordered {clr, step, run}.
    logic [2:0] btn_vec;
    logic [2:0] s1_q, s2_q, s3_q;
    logic [2:0] lvl;
    logic [2:0] edge_vec;
    logic [2:0] arm_q;
    logic       armed;

    assign btn_vec = {btn_clr, btn_step, btn_run};
    assign armed   = arm_q[2];

    // Edges stay masked until s3 has caught up with a button held through reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q  <= '0;
            s2_q  <= '0;
            s3_q  <= '0;
            arm_q <= '0;
        end else begin
            s1_q <= btn_vec;
            s2_q <= s1_q;
            s3_q <= lvl;
            if (!armed) begin
                arm_q <= arm_q + 3'd1;
            end
        end
    end

`ifdef COUNT_ENA_DEBOUNCE_EN
    logic [2:0]       lvl_q;
    logic [DEB_W-1:0] deb_cnt_q [3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvl_q <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!armed) begin
                    lvl_q[i]     <= s2_q[i];
                    deb_cnt_q[i] <= '0;
                end else if (s2_q[i] != lvl_q[i]) begin
                    if (deb_cnt_q[i] == '1) begin
                        lvl_q[i]     <= s2_q[i];
                        deb_cnt_q[i] <= '0;
                    end else begin
                        deb_cnt_q[i] <= deb_cnt_q[i] + DEB_W'(1);
                    end
                end else begin
                    deb_cnt_q[i] <= '0;
                end
            end
        end
    end

    assign lvl = lvl_q;
`else
    assign lvl = s2_q;
`endif

    assign edge_vec = lvl & ~s3_q & {3{armed}};

    logic                  run_edge, step_edge, clr_edge;
    logic [1:0]            state_q, state_d;
    logic [PRESCALE_W-1:0] pc_q, pc_d;
    logic                  tick;
    logic                  ena_q, ena_d;
    logic                  clr_q;
    logic                  running_q;

    assign run_edge  = edge_vec[0];
    assign step_edge = edge_vec[1];
    assign clr_edge  = edge_vec[2];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (run_edge) begin
                    state_d = ST_RUN;
                end else if (step_edge) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (run_edge) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The >= compare lets a lowered prescale tick immediately instead of wrapping.
    always_comb begin
        tick = (state_q == ST_RUN) && (state_d == ST_RUN) && (pc_q >= prescale);
        pc_d = '0;
        if (!clr_edge && (state_q == ST_RUN) && (state_d == ST_RUN) && !tick) begin
            pc_d = pc_q + PRESCALE_W'(1);
        end
        ena_d = !clr_edge && (tick || (state_d == ST_STEP));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            ena_q     <= 1'b0;
            clr_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ena_q     <= ena_d;
            clr_q     <= clr_edge;
            running_q <= (state_d == ST_RUN);
        end
    end

    assign ena     = ena_q;
    assign clr     = clr_q;
    assign running = running_q;

endmodule
